// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver. It synchronises the serial line,
// recovers bytes with a mid-bit sampling FSM and queues them in a small FIFO
// behind a valid/ready stream. Framing errors and overruns are sticky flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on the synced rx
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits at bit centres, LSB first
// STOP      | sample stop bit; high pushes the byte, low flags a frame error
// WAIT_HIGH | after a bad stop bit, hold off until the line returns high

module uart_rx_capture #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     overrun,
  input  logic                     clr_err,
  output logic [FIFO_DEPTH_LOG2:0] level
);

  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta, rx_s;
  logic          push, frame_set, tick;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok, overrun_set;

  // two-flop synchroniser; idle-high reset so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign tick = (cnt_q == '0);

  // next-state logic; timer counts down and a zero count marks a sample point
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = !empty && m_ready;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shift_q;
  end

  // FIFO pointers, one extra wrap bit distinguishes full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   || (frame_err && !clr_err);
      overrun   <= overrun_set || (overrun && !clr_err);
    end
  end

  assign m_valid = !empty;
  assign m_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: directed scenarios plus a randomized phase.
// Expected bytes go into a queue when frames are sent; a negedge monitor pops
// and compares whenever the DUT hands over a byte.

module tb_uart_rx_capture;

  localparam int C           = 8;
  localparam int N           = 2;
  localparam int STOP_SAMPLE = 2 + C / 2 + 9 * C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic         clr_err = 1'b0;
  logic         man_ready = 1'b0;
  logic         rnd_ready = 1'b0;
  bit           rand_ready = 1'b0;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         frame_err;
  logic         overrun;
  logic [N:0]   level;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  logic [7:0]   exp_q [$];
  logic [7:0]   exp_b;
  logic [7:0]   prev_data = 8'h00;
  bit           prev_stall = 1'b0;
  bit           exp_fe;
  logic [7:0]   rb;
  bit           rok;

  assign m_ready = rand_ready ? rnd_ready : man_ready;

  uart_rx_capture #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(N)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // advance n clock edges and land just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive one 8N1 frame; a bad stop bit is held low for extra_low more
  // cycles and then followed by one idle bit so the receiver can recover
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int abort_bit = -1, input int extra_low = 0);
    rx = 1'b0;
    start_cyc = cyc;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == abort_bit) begin
        tick(C / 2);
        return;
      end
      tick(C);
    end
    rx = stop_ok;
    tick(C);
    if (!stop_ok) begin
      tick(extra_low);
      rx = 1'b1;
      tick(C);
    end
    rx = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && m_valid) check("hold_data", m_data, prev_data);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_pop: got 0x%02h expected no byte at cycle %0d", m_data, cyc);
        end else begin
          exp_b = exp_q.pop_front();
          check("pop_data", m_data, exp_b);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    tick(3);
    check("rst_level", level, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(4);

    // single byte with stop-sample timing
    man_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        tick(STOP_SAMPLE);
        check("valid_before_stop", m_valid, 0);
        tick(1);
        check("valid_after_stop", m_valid, 1);
        tick(1);
        check("valid_one_pulse", m_valid, 0);
      end
    join
    tick(4);
    check("single_frame_err", frame_err, 0);
    check("single_overrun", overrun, 0);
    check("single_level", level, 0);

    // glitch shorter than half a bit is ignored
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("glitch_level", level, 0);
    check("glitch_valid", m_valid, 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(4);
    check("after_glitch_level", level, 0);

    // overrun: five bytes into a four-deep FIFO
    man_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    tick(2);
    check("ovr_level", level, 4);
    check("ovr_flag", overrun, 1);
    man_ready = 1'b1;
    tick(1);
    check("ovr_drain1", level, 3);
    tick(3);
    check("ovr_drain4", level, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);

    // framing error followed by a break
    send_frame(8'h3C, 1'b0, -1, 40);
    tick(4);
    check("break_frame_err", frame_err, 1);
    check("break_level", level, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("break_cleared", frame_err, 0);

    // simultaneous push and pop while full
    man_ready = 1'b0;
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(8'(8'h10 + v));
      send_frame(8'(8'h10 + v), 1'b1);
    end
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        tick(STOP_SAMPLE);
        man_ready = 1'b1;
        tick(1);
        man_ready = 1'b0;
        check("simul_level", level, 4);
        check("simul_overrun", overrun, 0);
      end
    join
    man_ready = 1'b1;
    tick(6);
    check("simul_drained", level, 0);

    // reset mid-frame with bytes queued
    man_ready = 1'b0;
    send_frame(8'h21, 1'b1);
    send_frame(8'h42, 1'b1);
    tick(2);
    check("pre_reset_level", level, 2);
    send_frame(8'h77, 1'b1, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_level", level, 0);
    check("midrst_valid", m_valid, 0);
    check("midrst_data", m_data, 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    man_ready = 1'b1;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    tick(4);
    check("post_reset_level", level, 0);

    // randomized frames with random consumer backpressure
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    exp_fe = 1'b0;
    rand_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 3) != 0);
      if (rok) exp_q.push_back(rb);
      else     exp_fe = 1'b1;
      send_frame(rb, rok);
      tick($urandom_range(0, C));
    end
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick(1);
    tick(2);
    check("rand_drained", exp_q.size(), 0);
    check("rand_frame_err", frame_err, exp_fe);
    check("rand_overrun", overrun, 0);
    check("rand_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
